// File: rtl/mem_port_arbiter_if.sv
// Purpose: bundles the fetch, execute and memory-port signals of mem_port_arbiter.
// Latency: none; this is a wire bundle.
// Backpressure: requesters hold their request until *_gnt is seen in the same cycle.
// Ports: slave = arbiter side (takes requests and mem_rdata, drives grants, rvalids and the memory port);
//        master = requester/memory side (the mirror image).
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;

  logic                  ex_req;
  logic [ADDR_W-1:0]     ex_addr;
  logic [DATA_W/8-1:0]   ex_we;
  logic [DATA_W-1:0]     ex_wdata;
  logic                  ex_gnt;
  logic                  ex_rvalid;
  logic [DATA_W-1:0]     ex_rdata;

  logic                  mem_en;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W/8-1:0]   mem_we;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ex_req, ex_addr, ex_we, ex_wdata,
    output ex_gnt, ex_rvalid, ex_rdata,
    output mem_en, mem_addr, mem_we, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ex_req, ex_addr, ex_we, ex_wdata,
    input  ex_gnt, ex_rvalid, ex_rdata,
    input  mem_en, mem_addr, mem_we, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Purpose: shares one data-memory port between fetch (reads) and execute (loads/stores).
// Latency: grant is combinational; access on the port 1 cycle later; read data RD_LAT cycles after that.
// Backpressure: a requester not granted this cycle stalls; fetch is forced through after STARVE_MAX denials.
// Ports: clk, rstn (async, active-low); bus (slave modport) carries fetch/execute requests,
//        grants, read responses and the registered memory port.
module mem_port_arbiter #(
  parameter int ADDR_W     = 64,
  parameter int DATA_W     = 64,
  parameter int RD_LAT     = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rstn,
  mem_port_arbiter_if.slave bus
);

  localparam int         BE_W       = DATA_W / 8;
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0]        starve_cnt;
  logic              if_win;
  logic              ex_win;
  logic              rd_win;

  logic              mem_en_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [BE_W-1:0]   mem_we_q;
  logic [DATA_W-1:0] mem_wdata_q;

  // One {valid, owner} pair per cycle of read latency plus the port register stage.
  // owner 0 = fetch, 1 = execute.
  logic [RD_LAT:0]   tag_vld;
  logic [RD_LAT:0]   tag_own;

  // Execute normally wins; fetch wins when alone or once it has been starved long enough.
  // Grants are held low while reset is asserted.
  always_comb begin
    if_win = 1'b0;
    ex_win = 1'b0;
    if (rstn) begin
      if_win = bus.if_req && (!bus.ex_req || (starve_cnt == STARVE_LIM));
      ex_win = bus.ex_req && !if_win;
    end
  end

  assign rd_win     = if_win || (ex_win && (bus.ex_we == '0));
  assign bus.if_gnt = if_win;
  assign bus.ex_gnt = ex_win;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      starve_cnt <= '0;
    end else if (if_win) begin
      starve_cnt <= '0;
    end else if (bus.if_req && (starve_cnt != STARVE_LIM)) begin
      starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Address and write data hold when idle so the port only toggles on real accesses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_en_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= '0;
      mem_wdata_q <= '0;
    end else if (if_win) begin
      mem_en_q    <= 1'b1;
      mem_addr_q  <= bus.if_addr;
      mem_we_q    <= '0;
    end else if (ex_win) begin
      mem_en_q    <= 1'b1;
      mem_addr_q  <= bus.ex_addr;
      mem_we_q    <= bus.ex_we;
      mem_wdata_q <= bus.ex_wdata;
    end else begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= '0;
    end
  end

  // Clearing the tags on reset is what drops in-flight reads; the memory keeps
  // returning data but nothing qualifies it any more.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_vld <= '0;
      tag_own <= '0;
    end else begin
      tag_vld <= {tag_vld[RD_LAT-1:0], rd_win};
      tag_own <= {tag_own[RD_LAT-1:0], ex_win};
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_wdata = mem_wdata_q;

  assign bus.if_rvalid = tag_vld[RD_LAT] && !tag_own[RD_LAT];
  assign bus.ex_rvalid = tag_vld[RD_LAT] &&  tag_own[RD_LAT];
  assign bus.if_rdata  = bus.mem_rdata;
  assign bus.ex_rdata  = bus.mem_rdata;

endmodule
